sumator_cla_pipeline: RTL and testbench
=======================================

// Module: sumator_cla_pipeline
// PURPOSE
//   Parametrised, pipelined carry look-ahead adder/subtractor. Replaces the fixed 16-bit
//   combinational CLA as the datapath adder and keeps the sum/carry semantics.
//   The carry chain is split into STAGES register slices, each built from 4-bit CLA groups.
//   Operands enter and results leave through valid/ready handshakes.
// PARAMETERS
//   WIDTH   16  operand/result width in bits; multiple of 4, range 4..64
//   STAGES  2   pipeline slices; WIDTH/STAGES must be a multiple of 4; range 1..WIDTH/4
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand set present on A/B/C_in/op_sub
//   in_ready   out  1      block accepts the operand set this cycle
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   C_in       in   1      carry-in (add) / borrow-in (sub)
//   op_sub     in   1      0: A+B+C_in ; 1: A-B-C_in
//   out_valid  out  1      Suma/C_out/ovf hold a result
//   out_ready  in   1      consumer takes the result this cycle
//   Suma       out  WIDTH  result, modulo 2^WIDTH
//   C_out      out  1      add: carry out; sub: 1 = no borrow (A >= B+C_in, unsigned)
//   ovf        out  1      two's-complement signed overflow of the result
// BEHAVIOUR
//   - Operand encoding: add uses B and cin=C_in. Sub uses ~B and cin=~C_in.
//     Both feed one CLA adder: {C_out,Suma} = A + B' + cin'.
//   - Slice k handles bits [k*W/S +: W/S]. It uses g=a&b and p=a^b per bit.
//     Group look-ahead runs inside the slice. The slice carry-out is registered into slice k+1.
//   - Skew/deskew registers: unprocessed upper operand bits are delayed to their slice.
//     Finished lower sum bits are delayed to the output. All bits of one result leave together.
//   - ovf = carry into MSB XOR carry out of MSB; it is valid in both modes.
//   - Global advance: adv = ~out_valid | out_ready. in_ready = adv (combinational).
//   - On adv, every stage register loads from its predecessor, including its valid bit.
//     The first stage captures in_valid & in_ready.
//   - When adv=0, all stages hold and in_ready=0. Bubbles are not collapsed.
//   - Latency: STAGES cycles from an accepted input to out_valid, with no stall.
//     Throughput: 1 result/cycle while out_ready=1.
//   - Outputs are registered. No combinational path runs from A/B to Suma.
//   - When out_valid=1 and out_ready=0, Suma/C_out/ovf stay stable until the handshake completes.
//   - Reset: all valid bits go to 0 and every data register goes to 0. Then out_valid=0,
//     Suma=0, C_out=0, ovf=0. in_ready=1 in the first cycle after reset.
//   - Reset mid-operation drops all in-flight results silently; none is emitted later.
//   - When in_valid=0 on an adv cycle, a bubble (valid=0) enters. Data registers may update,
//     but out_valid stays 0 for that slot.
//   - STAGES=1 reduces to one registered CLA with 1-cycle latency.
//   - Overflow wrap: sums beyond 2^WIDTH-1 wrap; C_out reports the carry.
// TESTING
//   - W=16,S=2: A=10,B=2,C_in=0,add, out_ready=1
//     -> after 2 clk, out_valid=1, Suma=12, C_out=0, ovf=0.
//   - A=5,B=12,C_in=1,add, issued the cycle after the previous test
//     -> next cycle Suma=18, C_out=0; back-to-back, 1/cycle.
//   - A=16'hFFFF,B=16'h0000,C_in=1,add (full carry ripple across slices)
//     -> Suma=0, C_out=1, ovf=0.
//     A=16'h7FFF,B=1,C_in=0 -> Suma=16'h8000, ovf=1.
//   - Sub: A=5,B=12,C_in=0 -> Suma=16'hFFF9, C_out=0.
//     A=12,B=5,C_in=1 -> Suma=6, C_out=1.
//     A=16'h8000,B=1 -> ovf=1.
//   - Backpressure: stream 4 ops with out_ready=0 from cycle 3.
//     -> in_ready=0, Suma frozen on the first result. Release: results exit in order, no loss/dup.
//   - rst=1 with 2 ops in flight -> next cycle out_valid=0, Suma=0, in_ready=1.
//     Neither op ever appears. Repeat the tests at W=32,S=4 and W=8,S=1.

Source files
------------

// File: rtl/sumator_cla_pipeline.sv
// sumator_cla_pipeline
//   Pipelined carry look-ahead adder/subtractor with valid/ready handshakes.
//   The WIDTH-bit carry chain is cut into STAGES slices of WIDTH/STAGES bits.
//   Each slice is built from 4-bit look-ahead groups, and each slice registers
//   its carry-out into the next slice.
//   Operand bits a slice has not reached yet travel alongside the carry in
//   skew registers. Finished low sum bits travel alongside the carry in deskew
//   registers. As a result, every bit of one result leaves in the same cycle.
//
//   Ports
//     clk, rst            rising-edge clock, synchronous active-high reset
//     in_valid, in_ready  input handshake (in_ready = pipeline may advance)
//     A, B, C_in, op_sub  operands; op_sub=1 computes A-B-C_in
//     out_valid,out_ready output handshake
//     Suma, C_out, ovf    registered result, carry (sub: 1 = no borrow),
//                         signed overflow
module sumator_cla_pipeline #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Suma,
  output logic             C_out,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;
  localparam int unsigned NG = SW / 4;

  logic             adv;
  logic [WIDTH-1:0] b_enc;
  logic             cin_enc;

  // The whole pipeline moves in lock-step. Bubbles are not squeezed out.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Subtraction becomes A + ~B + ~C_in, so one adder serves both modes.
  assign b_enc   = op_sub ? ~B : B;
  assign cin_enc = C_in ^ op_sub;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * SW;
    localparam int HI = LO + SW;
    localparam int RW = WIDTH - LO;   // operand bits not yet consumed

    logic [RW-1:0] a_in, b_in;
    logic          c_in_s, v_in;
    logic [SW:0]   c;
    logic [SW-1:0] g, p, s;
    logic [HI-1:0] s_next, s_q;
    logic          c_q, v_q;

    if (k == 0) begin : g_src
      always_comb begin
        a_in   = A;
        b_in   = b_enc;
        c_in_s = cin_enc;
        v_in   = in_valid & adv;
        s_next = s;
      end
    end else begin : g_src
      always_comb begin
        a_in   = stg[k-1].g_rem.a_q;
        b_in   = stg[k-1].g_rem.b_q;
        c_in_s = stg[k-1].c_q;
        v_in   = stg[k-1].v_q;
        s_next = {s, stg[k-1].s_q};
      end
    end

    // Each 4-bit group forms its carries in sum-of-products form from the
    // group carry-in. The group carry-out then feeds the next group.
    always_comb begin : cla
      logic t, pr;
      g    = a_in[SW-1:0] & b_in[SW-1:0];
      p    = a_in[SW-1:0] ^ b_in[SW-1:0];
      c    = '0;
      c[0] = c_in_s;
      for (int unsigned gi = 0; gi < NG; gi++) begin
        for (int unsigned i = 0; i < 4; i++) begin
          t = c[gi*4];
          for (int unsigned j = 0; j <= i; j++) t = t & p[gi*4+j];
          for (int unsigned j = 0; j <= i; j++) begin
            pr = g[gi*4+j];
            for (int unsigned m = j + 1; m <= i; m++) pr = pr & p[gi*4+m];
            t = t | pr;
          end
          c[gi*4+i+1] = t;
        end
      end
      s = p ^ c[SW-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= c[SW];
        s_q <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_rem
      logic [WIDTH-HI-1:0] a_q, b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[RW-1:SW];
          b_q <= b_in[RW-1:SW];
        end
      end
    end else begin : g_last
      logic ovf_q;
      always_ff @(posedge clk) begin
        if (rst)      ovf_q <= 1'b0;
        else if (adv) ovf_q <= c[SW] ^ c[SW-1];
      end
    end
  end

  assign Suma      = stg[STAGES-1].s_q;
  assign C_out     = stg[STAGES-1].c_q;
  assign out_valid = stg[STAGES-1].v_q;
  assign ovf       = stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_sumator_cla_pipeline.sv
// tb_sumator_cla_pipeline
//   Scoreboard bench for sumator_cla_pipeline at W8/S1, W16/S2 and W32/S4.
//   One instance is exercised at a time. The other instances are kept idle.
module tb_sumator_cla_pipeline;

  typedef struct {
    logic [31:0] suma;
    logic        cout;
    logic        ovf;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        cin, sub, iv, ordy;
  int          sel;

  int ws [3] = '{8, 16, 32};
  int ss [3] = '{1, 2, 4};

  logic       iv8, iv16, iv32, or8, or16, or32;
  logic       ir8, ir16, ir32, ov8, ov16, ov32;
  logic       co8, co16, co32, of8, of16, of32;
  logic [7:0] s8;
  logic [15:0] s16;
  logic [31:0] s32;

  assign iv8  = iv & (sel == 0);
  assign iv16 = iv & (sel == 1);
  assign iv32 = iv & (sel == 2);
  assign or8  = (sel == 0) ? ordy : 1'b1;
  assign or16 = (sel == 1) ? ordy : 1'b1;
  assign or32 = (sel == 2) ? ordy : 1'b1;

  sumator_cla_pipeline #(.WIDTH(8), .STAGES(1)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a[7:0]), .B(b[7:0]),
    .C_in(cin), .op_sub(sub), .out_valid(ov8), .out_ready(or8), .Suma(s8),
    .C_out(co8), .ovf(of8));
  sumator_cla_pipeline #(.WIDTH(16), .STAGES(2)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a[15:0]), .B(b[15:0]),
    .C_in(cin), .op_sub(sub), .out_valid(ov16), .out_ready(or16), .Suma(s16),
    .C_out(co16), .ovf(of16));
  sumator_cla_pipeline #(.WIDTH(32), .STAGES(4)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .A(a), .B(b),
    .C_in(cin), .op_sub(sub), .out_valid(ov32), .out_ready(or32), .Suma(s32),
    .C_out(co32), .ovf(of32));

  always #5 clk = ~clk;

  logic [31:0] o_suma;
  logic        o_valid, o_ir, o_cout, o_ovf;
  always_comb begin
    o_suma = '0; o_valid = 1'b0; o_ir = 1'b0; o_cout = 1'b0; o_ovf = 1'b0;
    case (sel)
      0: begin o_suma = {24'd0, s8}; o_valid = ov8;  o_ir = ir8;  o_cout = co8;  o_ovf = of8;  end
      1: begin o_suma = {16'd0, s16}; o_valid = ov16; o_ir = ir16; o_cout = co16; o_ovf = of16; end
      default: begin o_suma = s32; o_valid = ov32; o_ir = ir32; o_cout = co32; o_ovf = of32; end
    endcase
  end

  int   n_tests = 0, n_fail = 0, cyc = 0;
  exp_t sb[$];
  exp_t got_log[$];
  logic acc, lat_chk, stall_prev;
  logic [31:0] prev_suma;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (W=%0d): got %0h, expected %0h", tag, ws[sel], obs, exp);
    end
  endtask

  function automatic longint unsigned wmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: unsigned arithmetic for the sum and carry/borrow, and signed
  // range testing for the overflow.
  function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci, input logic sbv);
    exp_t e;
    longint unsigned m, ua, ub, ur;
    longint sa, sbs, r, smax;
    m   = wmask(w);
    ua  = av & m;
    ub  = bv & m;
    sa  = av[w-1] ? longint'(ua) - longint'(m + 1) : longint'(ua);
    sbs = bv[w-1] ? longint'(ub) - longint'(m + 1) : longint'(ub);
    smax = longint'(m >> 1);
    if (!sbv) begin
      ur = ua + ub + ci;
      e.cout = ur[w];
      r = sa + sbs + ci;
    end else begin
      ur = ua - ub - ci;
      e.cout = (ua >= ub + ci);
      r = sa - sbs - ci;
    end
    e.suma = 32'(ur & m);
    e.ovf  = (r > smax) || (r < -smax - 1);
    e.t    = 0;
    return e;
  endfunction

  // One clock. Handshakes are judged at the falling edge from the inputs that
  // the next rising edge will see.
  task automatic tick();
    exp_t e;
    acc = 1'b0;
    @(negedge clk);
    if (!rst) begin
      if (stall_prev) begin
        check("hold_suma", o_suma, prev_suma);
        check("hold_valid", o_valid, 1);
      end
      if (o_valid && !ordy) check("in_ready_stall", o_ir, 0);
      stall_prev = o_valid && !ordy;
      prev_suma  = o_suma;
      if (o_valid && ordy) begin
        if (sb.size() == 0) check("extra_result", o_valid, 0);
        else begin
          e = sb.pop_front();
          check("suma", o_suma, e.suma);
          check("c_out", o_cout, e.cout);
          check("ovf", o_ovf, e.ovf);
          if (lat_chk) check("latency", cyc - e.t, ss[sel]);
          got_log.push_back('{o_suma, o_cout, o_ovf, cyc});
        end
      end
      if (iv && o_ir) begin
        e = model(ws[sel], a, b, cin, sub);
        e.t = cyc;
        sb.push_back(e);
        acc = 1'b1;
      end
    end else stall_prev = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sbv);
    int n = 0;
    a = av; b = bv; cin = ci; sub = sbv; iv = 1'b1;
    do begin tick(); n++; end while (!acc && n < 20);
    if (!acc) check("send_timeout", acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    iv = 1'b0; ordy = 1'b1;
    while (sb.size() != 0 && n < 40) begin tick(); n++; end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic rand_op();
    logic [31:0] m;
    m   = 32'(wmask(ws[sel]));
    a   = $urandom & m;
    b   = $urandom & m;
    case ($urandom_range(0, 5))
      0: a = m;
      1: b = 32'(64'd1 << (ws[sel] - 1));
      2: b = 0;
      default: ;
    endcase
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [31:0] m;
    int k, t;
    rst = 1'b1; iv = 1'b0; ordy = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    lat_chk = 1'b0; stall_prev = 1'b0; prev_suma = '0; sel = 0;

    for (int cfg = 0; cfg < 3; cfg++) begin
      sel = cfg;
      m   = 32'(wmask(ws[sel]));
      rst = 1'b1; iv = 1'b0; ordy = 1'b1;
      tick(); tick();
      sb.delete();
      rst = 1'b0;
      check("rst_valid", o_valid, 0);
      check("rst_suma", o_suma, 0);
      check("rst_cout", o_cout, 0);
      check("rst_ovf", o_ovf, 0);
      check("rst_in_ready", o_ir, 1);

      // Back-to-back directed stream with no stalls: fixed latency, 1/cycle.
      lat_chk = 1'b1;
      got_log.delete();
      send(32'd10, 32'd2, 0, 0);
      send(32'd5, 32'd12, 1, 0);
      send(m, 32'd0, 1, 0);
      send(m >> 1, 32'd1, 0, 0);
      send(32'd5, 32'd12, 0, 1);
      send(32'd12, 32'd5, 1, 1);
      send(32'(64'd1 << (ws[sel] - 1)), 32'd1, 0, 1);
      send(32'd0, 32'd0, 1, 1);
      send(m, m, 1, 0);
      drain();
      lat_chk = 1'b0;

      if (sel == 1) begin
        check("spec_count", got_log.size(), 9);
        if (got_log.size() >= 7) begin
          check("spec_add_suma", got_log[0].suma, 12);
          check("spec_add_cout", got_log[0].cout, 0);
          check("spec_add2_suma", got_log[1].suma, 18);
          check("spec_ripple_suma", got_log[2].suma, 0);
          check("spec_ripple_cout", got_log[2].cout, 1);
          check("spec_ripple_ovf", got_log[2].ovf, 0);
          check("spec_posovf_suma", got_log[3].suma, 32'h8000);
          check("spec_posovf_ovf", got_log[3].ovf, 1);
          check("spec_sub_suma", got_log[4].suma, 32'hFFF9);
          check("spec_sub_cout", got_log[4].cout, 0);
          check("spec_sub2_suma", got_log[5].suma, 6);
          check("spec_sub2_cout", got_log[5].cout, 1);
          check("spec_negovf_ovf", got_log[6].ovf, 1);
        end
      end

      // Backpressure: four ops, consumer stalls from the third cycle.
      k = 0; t = 0;
      rand_op(); iv = 1'b1;
      while (k < 4 && t < 40) begin
        ordy = !(t >= 2 && t < 8);
        tick();
        if (acc) begin k++; rand_op(); end
        t++;
      end
      check("bp_accepted", k, 4);
      drain();

      // Random traffic with random stalls and bubbles.
      for (int i = 0; i < 150; i++) begin
        rand_op();
        iv   = 1'($urandom_range(0, 3) != 0);
        ordy = 1'($urandom_range(0, 2) != 0);
        tick();
      end
      drain();

      // Reset with operations in flight: none of them may ever emerge.
      ordy = 1'b0;
      rand_op(); iv = 1'b1; tick();
      rand_op(); tick();
      iv = 1'b0; rst = 1'b1; tick();
      sb.delete();
      rst = 1'b0;
      check("midrst_valid", o_valid, 0);
      check("midrst_suma", o_suma, 0);
      check("midrst_in_ready", o_ir, 1);
      ordy = 1'b1;
      repeat (10) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
